// File: rtl/div_pkg.sv
// div_pkg: shared state encoding and constants for the restoring divider
package div_pkg;
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;
  localparam logic [63:0] DIV0_QUOTIENT = '1;
endpackage

// File: rtl/sub_borrow.sv
// sub_borrow: combinational ripple subtractor, a + ~b + 1 with borrow as inverted carry-out
module sub_borrow #(
  parameter int N = 33
) (
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  output logic [N-1:0] o_diff,
  output logic         o_borrow
);
  logic [N:0]   w_c;
  logic [N-1:0] w_nb;
  assign w_nb   = ~i_b;
  assign w_c[0] = 1'b1;
  for (genvar i = 0; i < N; i++) begin : g_bit
    assign o_diff[i] = i_a[i] ^ w_nb[i] ^ w_c[i];
    assign w_c[i+1]  = (i_a[i] & w_nb[i]) | (w_c[i] & (i_a[i] ^ w_nb[i]));
  end
  assign o_borrow = ~w_c[N];
endmodule

// File: rtl/restoring_divider32.sv
// restoring_divider32: unsigned iterative restoring divider, one quotient bit per clock
module restoring_divider32
  import div_pkg::*;
#(
  parameter int W     = 32,
  parameter int CNT_W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder,
  output logic         div_by_zero
);
  state_t           r_state, w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [W:0]       r_rem;
  logic [W-1:0]     r_quo, r_div;
  logic             r_dbz;
  logic [W:0]       w_shift, w_trial;
  logic             w_borrow, w_div0, w_unused;
  assign w_shift     = {r_rem[W-1:0], r_quo[W-1]};
  assign w_div0      = divisor == '0;
  assign quotient    = r_quo;
  assign remainder   = r_rem[W-1:0];
  assign div_by_zero = r_dbz;
  assign w_unused    = r_rem[W];
  sub_borrow #(.N(W + 1)) u_sub (
    .i_a     (w_shift),
    .i_b     ({1'b0, r_div}),
    .o_diff  (w_trial),
    .o_borrow(w_borrow)
  );
  // state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end
  // next-state and handshake outputs
  always_comb begin
    in_ready  = r_state == S_IDLE;
    out_valid = r_state == S_DONE;
    w_next    = r_state == S_IDLE ? (in_valid ? (w_div0 ? S_DONE : S_RUN) : S_IDLE) :
                r_state == S_RUN  ? (r_cnt == '0 ? S_DONE : S_RUN) :
                                    (out_ready ? S_IDLE : S_DONE);
  end
  // operand capture, shift/subtract step and held results
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_rem <= '0;
      r_quo <= '0;
      r_div <= '0;
      r_dbz <= 1'b0;
    end else if (r_state == S_IDLE && in_valid) begin
      r_cnt <= CNT_W'(W - 1);
      r_rem <= w_div0 ? {1'b0, dividend} : '0;
      r_quo <= w_div0 ? W'(DIV0_QUOTIENT) : dividend;
      r_div <= divisor;
      r_dbz <= w_div0;
    end else if (r_state == S_RUN) begin
      r_cnt <= r_cnt - CNT_W'(r_cnt != '0);
      r_rem <= w_borrow ? w_shift : w_trial;
      r_quo <= {r_quo[W-2:0], ~w_borrow};
    end
  end
endmodule

// File: tb/tb_restoring_divider32.sv
// tb_restoring_divider32: directed and randomised checks of the restoring divider
module tb_restoring_divider32;
  logic        clk = 0, rst = 1, in_valid = 0, out_ready = 0;
  logic        in_ready, out_valid, div_by_zero;
  logic [31:0] dividend = 0, divisor = 0, quotient, remainder;
  int          n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  restoring_divider32 dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor), .out_valid(out_valid),
    .out_ready(out_ready), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int hold,
                        output logic [31:0] q, output logic [31:0] r, output logic z,
                        output int lat);
    int w;
    w = 0;
    while (!in_ready && w < 100) begin tick(); w++; end
    n_cmp++;
    if (in_ready !== 1'b1) begin n_bad++; $display("FAIL in_ready_wait: got %b want 1", in_ready); end
    dividend = a; divisor = b; in_valid = 1;
    tick();
    in_valid = 0; dividend = $urandom; divisor = $urandom;
    lat = 0;
    while (!out_valid && lat < 100) begin tick(); lat++; end
    q = quotient; r = remainder; z = div_by_zero;
    repeat (hold) tick();
    out_ready = 1;
    tick();
    out_ready = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (3) tick();
    rst = 0;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (quotient !== 32'd0) begin n_bad++; $display("FAIL rst_quotient: got %h want 0", quotient); end
    n_cmp++; if (remainder !== 32'd0) begin n_bad++; $display("FAIL rst_remainder: got %h want 0", remainder); end
    n_cmp++; if (div_by_zero !== 1'b0) begin n_bad++; $display("FAIL rst_dbz: got %b want 0", div_by_zero); end
  endtask

  task automatic test_basic();
    logic [31:0] va [4] = '{32'd100, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd5};
    logic [31:0] vb [4] = '{32'd7, 32'd1, 32'hFFFFFFFF, 32'd9};
    logic [31:0] vq [4] = '{32'd14, 32'hFFFFFFFF, 32'd1, 32'd0};
    logic [31:0] vr [4] = '{32'd2, 32'd0, 32'd0, 32'd5};
    logic [31:0] q, r;
    logic z;
    int lat;
    for (int i = 0; i < 4; i++) begin
      run_op(va[i], vb[i], 0, q, r, z, lat);
      n_cmp++; if (q !== vq[i]) begin n_bad++; $display("FAIL basic%0d_quotient: got %h want %h", i, q, vq[i]); end
      n_cmp++; if (r !== vr[i]) begin n_bad++; $display("FAIL basic%0d_remainder: got %h want %h", i, r, vr[i]); end
      n_cmp++; if (z !== 1'b0) begin n_bad++; $display("FAIL basic%0d_dbz: got %b want 0", i, z); end
      n_cmp++; if (lat !== 32) begin n_bad++; $display("FAIL basic%0d_latency: got %0d want 32", i, lat); end
    end
  endtask

  task automatic test_div_zero();
    logic [31:0] q, r;
    logic z;
    int lat;
    run_op(32'd1234, 32'd0, 0, q, r, z, lat);
    n_cmp++; if (lat !== 0) begin n_bad++; $display("FAIL dz_latency: got %0d want 0", lat); end
    n_cmp++; if (q !== 32'hFFFFFFFF) begin n_bad++; $display("FAIL dz_quotient: got %h want ffffffff", q); end
    n_cmp++; if (r !== 32'd1234) begin n_bad++; $display("FAIL dz_remainder: got %0d want 1234", r); end
    n_cmp++; if (z !== 1'b1) begin n_bad++; $display("FAIL dz_flag: got %b want 1", z); end
    n_cmp++; if (div_by_zero !== 1'b1) begin n_bad++; $display("FAIL dz_flag_after_hs: got %b want 1", div_by_zero); end
    run_op(32'd8, 32'd2, 0, q, r, z, lat);
    n_cmp++; if (z !== 1'b0) begin n_bad++; $display("FAIL dz_clear: got %b want 0", z); end
    n_cmp++; if (q !== 32'd4) begin n_bad++; $display("FAIL dz_next_quotient: got %0d want 4", q); end
    n_cmp++; if (r !== 32'd0) begin n_bad++; $display("FAIL dz_next_remainder: got %0d want 0", r); end
  endtask

  task automatic test_backpressure();
    int w;
    w = 0;
    while (!in_ready && w < 100) begin tick(); w++; end
    dividend = 32'd200; divisor = 32'd9; in_valid = 1;
    tick();
    in_valid = 0;
    w = 0;
    while (!out_valid && w < 100) begin tick(); w++; end
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL bp_out_valid_wait: got %b want 1", out_valid); end
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0]; dividend = $urandom; divisor = $urandom_range(0, 5);
      tick();
      n_cmp++; if (quotient !== 32'd22) begin n_bad++; $display("FAIL bp%0d_quotient: got %0d want 22", i, quotient); end
      n_cmp++; if (remainder !== 32'd2) begin n_bad++; $display("FAIL bp%0d_remainder: got %0d want 2", i, remainder); end
      n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL bp%0d_out_valid: got %b want 1", i, out_valid); end
      n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp%0d_in_ready: got %b want 0", i, in_ready); end
    end
    in_valid = 0; out_ready = 1;
    tick();
    out_ready = 0;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_release_in_ready: got %b want 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_release_out_valid: got %b want 0", out_valid); end
  endtask

  task automatic test_reset_mid_run();
    logic [31:0] q, r;
    logic z;
    int lat;
    dividend = 32'd1000; divisor = 32'd3; in_valid = 1;
    tick();
    in_valid = 0;
    repeat (12) tick();
    rst = 1;
    tick();
    rst = 0;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL mid_rst_in_ready: got %b want 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL mid_rst_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (quotient !== 32'd0) begin n_bad++; $display("FAIL mid_rst_quotient: got %h want 0", quotient); end
    n_cmp++; if (remainder !== 32'd0) begin n_bad++; $display("FAIL mid_rst_remainder: got %h want 0", remainder); end
    run_op(32'd1000, 32'd3, 0, q, r, z, lat);
    n_cmp++; if (q !== 32'd333) begin n_bad++; $display("FAIL mid_rst_redo_quotient: got %0d want 333", q); end
    n_cmp++; if (r !== 32'd1) begin n_bad++; $display("FAIL mid_rst_redo_remainder: got %0d want 1", r); end
    n_cmp++; if (lat !== 32) begin n_bad++; $display("FAIL mid_rst_redo_latency: got %0d want 32", lat); end
  endtask

  task automatic test_random();
    logic [31:0] a, b, q, r, eq, er;
    logic [63:0] recon;
    logic z;
    int lat, elat, mode;
    for (int i = 0; i < 300; i++) begin
      mode = $urandom_range(0, 9);
      a = $urandom;
      b = mode == 0 ? 32'd1 :
          mode == 1 ? a :
          mode == 2 ? (32'd1 << $urandom_range(0, 31)) :
          mode == 3 ? 32'($urandom_range(1, 255)) :
          mode == 4 ? 32'd0 :
          mode == 5 ? (a >> $urandom_range(1, 31)) : $urandom;
      eq = b == 0 ? 32'hFFFFFFFF : a / b;
      er = b == 0 ? a : a % b;
      elat = b == 0 ? 0 : 32;
      run_op(a, b, $urandom_range(0, 3), q, r, z, lat);
      n_cmp++; if (q !== eq) begin n_bad++; $display("FAIL rnd%0d_quotient %h/%h: got %h want %h", i, a, b, q, eq); end
      n_cmp++; if (r !== er) begin n_bad++; $display("FAIL rnd%0d_remainder %h/%h: got %h want %h", i, a, b, r, er); end
      n_cmp++; if (z !== (b == 0)) begin n_bad++; $display("FAIL rnd%0d_dbz: got %b want %b", i, z, b == 0); end
      n_cmp++; if (lat !== elat) begin n_bad++; $display("FAIL rnd%0d_latency: got %0d want %0d", i, lat, elat); end
      if (b != 0) begin
        recon = {32'd0, q} * {32'd0, b} + {32'd0, r};
        n_cmp++;
        if (recon !== {32'd0, a} || r >= b) begin
          n_bad++;
          $display("FAIL rnd%0d_invariant: got q*d+r=%h r=%h want %h with r<%h", i, recon, r, a, b);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_div_zero();
    test_backpressure();
    test_reset_mid_run();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
